// File: rtl/mem_bus_ctrl_pkg.sv
// Shared constants and types for the memory bus controller.
// The FSM state enum lives here so the datapath and the bench agree on encodings.
package mem_bus_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  // Read buffer value returned when an access is abandoned.
  localparam logic [DATA_W-1:0] ABORT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_bus_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tridrive.sv
// Tristate driver: puts data on bus while en is high, otherwise releases it.
module tridrive #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = en ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns active-low datapath read/write requests into a
// held mem_req handshake with a bounded wait, error reporting and a read buffer.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] MDRout,
  input  logic              re_L,
  input  logic              we_L,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic              memReady,
  output logic              busError,
  output logic [CNT_W-1:0]  errCount,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  mem_bus_state_t    state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] rbuf;
  logic              err_flag;
  logic              drive_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      memReady  <= 1'b0;
      busError  <= 1'b0;
      errCount  <= '0;
      wait_cnt  <= '0;
      rbuf      <= '0;
      err_flag  <= 1'b0;
      drive_en  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!re_L && !we_L) begin
            // Conflicting request: report it without touching memory.
            err_flag <= 1'b1;
            memReady <= 1'b1;
            busError <= 1'b1;
            drive_en <= 1'b0;
            state    <= ST_DONE;
          end else if (re_L ^ we_L) begin
            mem_addr  <= memAddr;
            mem_wdata <= MDRout;
            mem_we    <= ~we_L;
            wait_cnt  <= '0;
            mem_req   <= 1'b1;
            state     <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (mem_ack) begin
            rbuf     <= mem_rdata;
            mem_req  <= 1'b0;
            memReady <= 1'b1;
            busError <= err_flag;
            drive_en <= ~mem_we;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              rbuf     <= ABORT_DATA;
              err_flag <= 1'b1;
              mem_req  <= 1'b0;
              memReady <= 1'b1;
              busError <= 1'b1;
              drive_en <= ~mem_we;
              state    <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (busError) errCount <= sat_inc(errCount);
          memReady <= 1'b0;
          busError <= 1'b0;
          err_flag <= 1'b0;
          drive_en <= 1'b0;
          mem_req  <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  tridrive #(.WIDTH(DATA_W)) u_drv (
    .data (rbuf),
    .en   (drive_en),
    .bus  (dataBus)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl (TIMEOUT=4): stimulus queues expected
// completions, a negedge monitor checks every memReady against the queue.
module tb_mem_bus_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] memAddr, MDRout, mem_rdata;
  logic        re_L, we_L, mem_ack;
  wire  [15:0] dataBus;
  logic        memReady, busError, mem_req, mem_we;
  logic [7:0]  errCount;
  logic [15:0] mem_addr, mem_wdata;

  // A released bus reads as zero.
  pulldown (dataBus);

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .memAddr(memAddr), .MDRout(MDRout),
    .re_L(re_L), .we_L(we_L), .dataBus(dataBus), .memReady(memReady),
    .busError(busError), .errCount(errCount), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        berr;
    logic [15:0] data;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic berr, input logic [15:0] data);
    exp_t e;
    e.berr = berr;
    e.data = data;
    e.ecnt = 8'(exp_err);
    q.push_back(e);
    if (berr && exp_err < 255) exp_err++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Wait for memReady, then return one tick into the following IDLE cycle.
  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clock);
      if (memReady === 1'b1) seen = 1;
    end
    if (!seen) chk("wait_done_timeout", 32'd0, 32'd1);
    tick(1);
  endtask

  always @(negedge clock) begin
    if (memReady === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("busError", 32'(busError), 32'(mon_e.berr));
        chk("dataBus", 32'(dataBus), 32'(mon_e.data));
        chk("errCount", 32'(errCount), 32'(mon_e.ecnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1; re_L = 1; we_L = 1; mem_ack = 0;
    memAddr = 0; MDRout = 0; mem_rdata = 0;
    tick(2);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_memReady", 32'(memReady), 0);
    chk("rst_errCount", 32'(errCount), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_dataBus", 32'(dataBus), 0);
    reset = 0;
    tick(1);

    // Read, ack one cycle after mem_req; request dropped mid-access.
    re_L = 0; memAddr = 16'h0040;
    push(0, 16'hBEEF);
    tick(1);
    re_L = 1; memAddr = 16'h0000;
    chk("rd_mem_req", 32'(mem_req), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0040);
    tick(1);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick(1);
    mem_ack = 0; mem_rdata = 0;
    chk("rd_ready_4th", 32'(memReady), 1);
    wait_done(5);

    // Write with inputs changed mid-access; ack carries data that must stay off the bus.
    we_L = 0; memAddr = 16'h1234; MDRout = 16'hA5A5;
    push(0, 16'h0000);
    tick(1);
    we_L = 1; memAddr = 16'hFFFF; MDRout = 16'h0000;
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_wdata_a1", 32'(mem_wdata), 32'hA5A5);
    tick(1);
    chk("wr_wdata_a2", 32'(mem_wdata), 32'hA5A5);
    chk("wr_addr_a2", 32'(mem_addr), 32'h1234);
    tick(1);
    mem_ack = 1; mem_rdata = 16'h5555;
    chk("wr_wdata_a3", 32'(mem_wdata), 32'hA5A5);
    tick(1);
    mem_ack = 0; mem_rdata = 0;
    wait_done(5);

    // Timeout read: mem_req held for exactly 4 cycles.
    re_L = 0; memAddr = 16'h0080;
    push(1, 16'hFFFF);
    tick(1);
    re_L = 1;
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_req_hi", 32'(mem_req), 1);
      tick(1);
    end
    chk("to_mem_req_lo", 32'(mem_req), 0);
    wait_done(5);
    chk("to_errCount", 32'(errCount), 1);

    // Ack on the last allowed cycle wins over the timeout.
    re_L = 0; memAddr = 16'h0090;
    push(0, 16'h1357);
    tick(1);
    re_L = 1;
    tick(3);
    mem_ack = 1; mem_rdata = 16'h1357;
    tick(1);
    mem_ack = 0; mem_rdata = 0;
    wait_done(5);
    chk("ack_last_errCount", 32'(errCount), 1);

    // Both requests low: error without a memory request.
    re_L = 0; we_L = 0;
    push(1, 16'h0000);
    tick(1);
    re_L = 1; we_L = 1;
    chk("ill_mem_req", 32'(mem_req), 0);
    chk("ill_ready_next", 32'(memReady), 1);
    wait_done(5);
    chk("ill_errCount", 32'(errCount), 2);

    // Ack outside ACCESS produces nothing.
    mem_ack = 1;
    tick(3);
    mem_ack = 0;
    chk("stray_ack_req", 32'(mem_req), 0);

    // Reset in the middle of an access.
    re_L = 0; memAddr = 16'h0100;
    tick(1);
    re_L = 1;
    tick(1);
    reset = 1;
    tick(1);
    reset = 0;
    exp_err = 0;
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_ready", 32'(memReady), 0);
    chk("rst_mid_errCount", 32'(errCount), 0);
    mem_ack = 1; mem_rdata = 16'h7777;
    tick(2);
    chk("rst_ack_ignored", 32'(memReady), 0);
    mem_ack = 0;
    tick(1);

    // Held read with no ack: back-to-back timeouts saturate errCount.
    re_L = 0; memAddr = 16'h0200;
    for (int i = 0; i < 300; i++) begin
      push(1, 16'hFFFF);
      wait_done(12);
      if (i == 0) begin
        chk("b2b_idle_req", 32'(mem_req), 0);
        tick(1);
        chk("b2b_new_req", 32'(mem_req), 1);
      end
    end
    re_L = 1;
    tick(2);
    chk("sat_errCount", 32'(errCount), 32'hFF);
    tick(3);
    chk("pending_expected", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL be the maximum ACCESS cycles without mem_ack before abort (legal range 1..255).
REQ-002 Ports, in order:
- clock  input  1  sole clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- memAddr  input  16  access address from the datapath MAR.
- MDRout  input  16  write data from the datapath MDR.
- re_L  input  1  read request, active-low.
- we_L  input  1  write request, active-low.
- dataBus  inout  16  read data to the datapath; driven only as in REQ-012, else high-Z.
- memReady  output  1  one-cycle access-complete strobe to the control path.
- busError  output  1  one-cycle error strobe, coincident with memReady.
- errCount  output  8  saturating count of errored accesses.
- mem_req  output  1  memory request, held for the whole access.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  output  16  registered memory address.
- mem_wdata  output  16  registered write data.
- mem_ack  input  1  memory completion, sampled only in ACCESS.
- mem_rdata  input  16  read data, valid when mem_ack = 1.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-004 IDLE, exactly one of re_L/we_L low: SHALL capture memAddr into mem_addr, MDRout into mem_wdata, (we_L == 0) into mem_we; clear the wait counter; go to ACCESS.
REQ-005 IDLE, re_L and we_L both low: SHALL issue no memory request, set the error flag, go to DONE.
REQ-006 ACCESS: mem_req SHALL be 1 and mem_addr/mem_wdata/mem_we SHALL stay constant.
REQ-007 ACCESS with mem_ack = 1: SHALL latch mem_rdata into the read buffer and go to DONE.
REQ-008 ACCESS with mem_ack = 0: SHALL increment the 8-bit wait counter.
- Counter reaching TIMEOUT-1 with mem_ack = 0: SHALL load the read buffer with 16'hFFFF, set the error flag, go to DONE.
REQ-009 mem_ack on the timeout cycle SHALL take priority; that access is not an error.
REQ-010 DONE SHALL assert memReady for exactly one cycle, with busError = error flag, then go to IDLE unconditionally, deassert mem_req and clear the error flag.
REQ-011 A request still held in the IDLE cycle after DONE SHALL start a new access (back-to-back).
- Minimum access: 3 cycles (IDLE accept, ACCESS with ack, DONE).
REQ-012 dataBus SHALL be driven with the read buffer only in DONE, for a read that is not an illegal both-low request.
REQ-013 Request deasserted mid-ACCESS SHALL NOT abort the access; it completes normally, including memReady.
REQ-014 mem_ack outside ACCESS SHALL be ignored.
REQ-015 errCount SHALL increment on each DONE with busError = 1 and saturate at 8'hFF.

Reset
REQ-016 On reset the block SHALL enter IDLE with all of these zero: mem_req, mem_we, mem_addr, mem_wdata, memReady, busError, errCount, wait counter, read buffer, error flag. dataBus SHALL be high-Z.
REQ-017 Reset SHALL take priority over all other inputs, including mid-ACCESS; the next cycle has mem_req = 0 and no memReady.

Structure
REQ-018 The state enum mem_bus_state_t SHALL be defined in the shared constants package; TIMEOUT stays a module parameter.
REQ-019 The dataBus driver SHALL be one instance of the existing tridrive module (WIDTH 16); no other sub-module.

Verification
REQ-020 Read: re_L=0, memAddr=16'h0040; mem_ack one cycle after mem_req, mem_rdata=16'hBEEF -> mem_we=0, mem_addr=16'h0040, memReady in 3rd or 4th cycle, dataBus=16'hBEEF, busError=0.
REQ-021 Write: we_L=0, memAddr=16'h1234, MDRout=16'hA5A5; mem_ack after 5 cycles -> mem_we=1, mem_wdata=16'hA5A5 stable throughout, single memReady, dataBus high-Z.
REQ-022 Timeout, TIMEOUT=4, read, mem_ack never -> mem_req high 4 cycles, then memReady=busError=1, dataBus=16'hFFFF, errCount=1. Repeat with mem_ack on the 4th cycle -> no error.
REQ-023 re_L=we_L=0 -> mem_req never rises, memReady=busError=1 on the next cycle, errCount increments, dataBus high-Z.
REQ-024 Reset asserted during ACCESS -> next cycle mem_req=0, memReady=0, errCount=0; later mem_ack ignored.
REQ-025 300 consecutive timeouts -> errCount saturates at 8'hFF. Back-to-back held re_L -> new mem_req the cycle after IDLE.
